// File: rtl/bs_frame_pkg.sv
// Shared types and constants for the backscatter frame generator.
// CRC-8 support is compiled in only when BS_FRAME_CRC8_EN is defined.
package bs_frame_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Manchester half-symbol phases: the first half carries the bit, the second its complement
  localparam logic PHASE_FIRST  = 1'b0;
  localparam logic PHASE_SECOND = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_TAIL = 3'd5
  } state_t;

  function automatic logic man_half(input logic b, input logic phase);
    return b ^ phase;
  endfunction

  // One MSB-first serial step of CRC-8, no reflection
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic [7:0] nxt;
    nxt = {crc[6:0], 1'b0};
    if (crc[7] ^ b) nxt = nxt ^ CRC8_POLY;
    return nxt;
  endfunction

endpackage

// File: rtl/bs_frame_gen_crc8.sv
// Serial CRC-8 over transmitted payload bits; exists only when BS_FRAME_CRC8_EN is defined.
`ifdef BS_FRAME_CRC8_EN
module crc8_serial
  import bs_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  always_ff @(posedge clk) begin
    if (rst)            crc_out <= CRC8_INIT;
    else if (clr)       crc_out <= CRC8_INIT;
    else if (bit_valid) crc_out <= crc8_step(crc_out, bit_in);
  end

endmodule
`endif

// File: rtl/bs_frame_gen.sv
// Backscatter frame generator: on a packet-detect edge, waits a guard delay then Manchester-serialises
// preamble, payload and (with BS_FRAME_CRC8_EN) a CRC-8 on asw_out.
module bs_frame_gen
  import bs_frame_pkg::*;
#(
  parameter int unsigned       SYM_DIV    = 20,
  parameter int unsigned       TRIG_DELAY = 100,
  parameter int unsigned       PRE_W      = 8,
  parameter logic [PRE_W-1:0]  PREAMBLE   = 8'hA5,
  parameter int unsigned       PAYLOAD_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dect_in,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 payload_load,
  output logic                 asw_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned TOT_W = PRE_W + PAYLOAD_W;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 phase;
  logic                 dect_q;
  logic [PAYLOAD_W-1:0] shadow;
  logic [TOT_W-1:0]     sr;

  logic                 trig_c;
  logic                 half_end_c;
  logic                 bit_last_c;
  logic                 cur_bit_c;
  logic                 nxt_bit_c;
  logic [CNT_W-1:0]     bit_lim_c;
  logic [PAYLOAD_W-1:0] load_val_c;

  assign trig_c     = dect_in & ~dect_q & en & (state == ST_IDLE);
  assign load_val_c = payload_load ? payload_i : shadow;
  assign half_end_c = (cnt == CNT_W'(SYM_DIV - 1));
  assign cur_bit_c  = sr[TOT_W-1];
  assign nxt_bit_c  = sr[TOT_W-2];
  assign bit_last_c = (bit_cnt == bit_lim_c);

  always_comb begin
    bit_lim_c = CNT_W'(PAYLOAD_W - 1);
    case (state)
      ST_PRE:  bit_lim_c = CNT_W'(PRE_W - 1);
      ST_CRC:  bit_lim_c = CNT_W'(7);
      default: bit_lim_c = CNT_W'(PAYLOAD_W - 1);
    endcase
  end

`ifdef BS_FRAME_CRC8_EN
  logic [7:0] crc;

  // Payload bits are folded in at mid-symbol so the CRC is settled before the last data bit ends
  crc8_serial u_crc (
    .clk       (clk),
    .rst       (rst),
    .clr       (trig_c),
    .bit_valid ((state == ST_DATA) && (phase == PHASE_FIRST) && half_end_c),
    .bit_in    (cur_bit_c),
    .crc_out   (crc)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      phase      <= PHASE_FIRST;
      dect_q     <= 1'b0;
      shadow     <= '0;
      sr         <= '0;
      asw_out    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dect_q     <= dect_in;
      frame_done <= 1'b0;
      if (payload_load) shadow <= payload_i;

      if (!en && (state != ST_IDLE)) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        bit_cnt <= '0;
        phase   <= PHASE_FIRST;
        asw_out <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            asw_out <= 1'b0;
            if (trig_c) begin
              state <= ST_WAIT;
              cnt   <= '0;
              busy  <= 1'b1;
              sr    <= {PREAMBLE, load_val_c};
            end
          end

          ST_WAIT: begin
            if (cnt == CNT_W'(TRIG_DELAY)) begin
              state   <= ST_PRE;
              cnt     <= '0;
              bit_cnt <= '0;
              phase   <= PHASE_FIRST;
              asw_out <= man_half(cur_bit_c, PHASE_FIRST);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_PRE, ST_DATA, ST_CRC: begin
            if (!half_end_c) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              cnt <= '0;
              if (phase == PHASE_FIRST) begin
                phase   <= PHASE_SECOND;
                asw_out <= man_half(cur_bit_c, PHASE_SECOND);
              end else begin
                phase <= PHASE_FIRST;
                if (!bit_last_c) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  sr      <= {sr[TOT_W-2:0], 1'b0};
                  asw_out <= man_half(nxt_bit_c, PHASE_FIRST);
                end else begin
                  bit_cnt <= '0;
                  case (state)
                    ST_PRE: begin
                      state   <= ST_DATA;
                      sr      <= {sr[TOT_W-2:0], 1'b0};
                      asw_out <= man_half(nxt_bit_c, PHASE_FIRST);
                    end
`ifdef BS_FRAME_CRC8_EN
                    ST_DATA: begin
                      state   <= ST_CRC;
                      sr      <= {crc, (TOT_W-8)'(0)};
                      asw_out <= man_half(crc[7], PHASE_FIRST);
                    end
`endif
                    default: begin
                      state   <= ST_TAIL;
                      asw_out <= 1'b0;
                    end
                  endcase
                end
              end
            end
          end

          ST_TAIL: begin
            asw_out <= 1'b0;
            if (half_end_c) begin
              state      <= ST_IDLE;
              cnt        <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          default: begin
            state   <= ST_IDLE;
            asw_out <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
